// File: rtl/fp_accumulator_pkg.sv
// Shared FP32 field layout, constants and state encoding for the streaming accumulator.
package fp_accumulator_pkg;
    localparam int SIGN_BIT = 31;
    localparam int EXP_MSB  = 30;
    localparam int EXP_LSB  = 23;
    localparam int MANT_MSB = 22;
    localparam int MANT_LSB = 0;

    localparam logic [31:0] FP32_ZERO = 32'h0000_0000;
    localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;

    typedef logic [1:0] state_t;
    localparam state_t IDLE  = 2'd0;
    localparam state_t ACCUM = 2'd1;
    localparam state_t DONE  = 2'd2;

    // Either sign of zero counts as zero.
    function automatic logic is_zero(input logic [31:0] f);
        return f[EXP_MSB:MANT_LSB] == '0;
    endfunction
endpackage

// File: rtl/fp_accumulator_if.sv
// Operand stream in, result stream out; the accumulator is the slave side.
interface fp_accumulator_if #(parameter int CNT_W = 16);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_sum;
    logic [CNT_W-1:0] out_count;
    logic             out_overflow;
    logic             out_underflow;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_count, out_overflow, out_underflow
    );
    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_count, out_overflow, out_underflow
    );
endinterface

// File: rtl/fp_accumulator_adder.sv
// Combinational FP32 adder, round-to-nearest-even, with gradual underflow.
module fp_adder
    import fp_accumulator_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] sum,
    output logic        overflow,
    output logic        underflow
);
    logic [31:0] x, y;
    logic [7:0]  ex, ey, d;
    logic [23:0] mx, my;
    logic [26:0] ax, ay, mask;
    logic [27:0] sa, sn;
    logic [9:0]  e, sh, ef;
    logic [4:0]  lz;
    logic [24:0] rm;
    logic [22:0] mant;
    logic        inc;

    always_comb begin
        // x is the larger magnitude, so alignment only ever shifts y
        x = a;
        y = b;
        if (b[EXP_MSB:MANT_LSB] > a[EXP_MSB:MANT_LSB]) begin
            x = b;
            y = a;
        end
        ex   = x[EXP_MSB:EXP_LSB];
        ey   = y[EXP_MSB:EXP_LSB];
        mx   = {ex != 8'd0, x[MANT_MSB:MANT_LSB]};
        my   = {ey != 8'd0, y[MANT_MSB:MANT_LSB]};
        d    = (ex == 8'd0 ? 8'd1 : ex) - (ey == 8'd0 ? 8'd1 : ey);
        e    = {2'b00, (ex == 8'd0 ? 8'd1 : ex)};
        ax   = {mx, 3'b000};
        mask = '0;
        if (d > 8'd26) begin
            ay = {26'd0, |my};
        end else begin
            mask = (27'd1 << d) - 27'd1;
            ay   = ({my, 3'b000} >> d) | {26'd0, |({my, 3'b000} & mask)};
        end

        if (x[SIGN_BIT] == y[SIGN_BIT]) sa = {1'b0, ax} + {1'b0, ay};
        else                            sa = {1'b0, ax} - {1'b0, ay};

        lz = 5'd27;
        sh = '0;
        if (sa[27]) begin
            sn = {1'b0, sa[27:2], sa[1] | sa[0]};
            e  = e + 10'd1;
        end else begin
            for (int i = 0; i < 27; i++)
                if (sa[i]) lz = 5'(26 - i);
            // never normalise below the minimum exponent: the leftover is a subnormal
            sh = ({5'd0, lz} < e - 10'd1) ? {5'd0, lz} : e - 10'd1;
            sn = sa << sh;
            e  = e - sh;
        end

        inc  = sn[2] & (sn[1] | sn[0] | sn[3]);
        rm   = {1'b0, sn[26:3]} + {24'd0, inc};
        ef   = rm[24] ? e + 10'd1 : (rm[23] ? e : 10'd0);
        mant = rm[24] ? rm[23:1] : rm[22:0];

        sum       = {x[SIGN_BIT], ef[7:0], mant};
        overflow  = 1'b0;
        underflow = (ef == 10'd0);
        if (ef >= 10'd255) begin
            sum      = {x[SIGN_BIT], 8'hFF, 23'd0};
            overflow = 1'b1;
        end
        if (sa == '0) begin
            sum       = {x[SIGN_BIT] & y[SIGN_BIT], 31'd0};
            underflow = 1'b0;
        end
        if (ex == 8'hFF) begin
            overflow  = 1'b0;
            underflow = 1'b0;
            if (x[MANT_MSB:MANT_LSB] != '0)
                sum = FP32_QNAN;
            else if (ey == 8'hFF && x[SIGN_BIT] != y[SIGN_BIT])
                sum = FP32_QNAN;
            else
                sum = x;
        end
    end
endmodule

// File: rtl/fp_accumulator.sv
// Streaming FP32 accumulator: one add per accepted operand, result held until consumed.
module fp_accumulator
    import fp_accumulator_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    fp_accumulator_if.slave   bus
);
    state_t           state, state_nxt;
    logic [31:0]      acc, add_sum;
    logic [CNT_W-1:0] count;
    logic             ovf, unf, add_ovf, add_unf;
    logic             ready, valid, take, give;

    fp_adder u_add (
        .a         (acc),
        .b         (bus.in_data),
        .sum       (add_sum),
        .overflow  (add_ovf),
        .underflow (add_unf)
    );

    assign take = bus.in_valid & ready;
    assign give = valid & bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, ACCUM: if (take) state_nxt = bus.in_last ? DONE : ACCUM;
            DONE:        if (give) state_nxt = IDLE;
            default:     state_nxt = IDLE;
        endcase
    end

    // ready is gated by rst_n so it reads 0 while reset is held
    always_comb begin
        ready = rst_n && (state != DONE);
        valid = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= FP32_ZERO;
            count <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else if (give) begin
            acc   <= FP32_ZERO;
            count <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else if (take) begin
            if (count != '1) count <= count + CNT_W'(1);
            if (state == IDLE) begin
                acc <= is_zero(bus.in_data) ? FP32_ZERO : bus.in_data;
            end else if (!is_zero(bus.in_data)) begin
                if (is_zero(acc)) begin
                    acc <= bus.in_data;
                end else begin
                    acc <= add_sum;
                    ovf <= ovf | add_ovf;
                    unf <= unf | add_unf;
                end
            end
        end
    end

    assign bus.in_ready      = ready;
    assign bus.out_valid     = valid;
    assign bus.out_sum       = acc;
    assign bus.out_count     = count;
    assign bus.out_overflow  = ovf;
    assign bus.out_underflow = unf;
endmodule

// File: tb/tb_fp_accumulator.sv
// Directed bench for fp_accumulator: hand-computed FP32 sums, counts and flags.
module tb_fp_accumulator;
    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    fp_accumulator_if #(.CNT_W(16)) bus ();

    fp_accumulator #(.CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; the transfer happens on the next rising edge.
    task automatic push(input logic [31:0] d, input logic l);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = l;
        chk("in_ready_on_push", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic expect_result(input string tag, input logic [31:0] s, input logic [15:0] c,
                                 input logic o, input logic u);
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, "_sum"}, bus.out_sum, s);
        chk({tag, "_count"}, 32'(bus.out_count), 32'(c));
        chk({tag, "_ovf"}, 32'(bus.out_overflow), 32'(o));
        chk({tag, "_unf"}, 32'(bus.out_underflow), 32'(u));
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk({tag, "_valid_clr"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_ready_back"}, 32'(bus.in_ready), 32'd1);
        chk({tag, "_count_clr"}, 32'(bus.out_count), 32'd0);
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_sum", bus.out_sum, 32'd0);
        chk("rst_out_count", 32'(bus.out_count), 32'd0);
        chk("rst_ovf", 32'(bus.out_overflow), 32'd0);
        chk("rst_unf", 32'(bus.out_underflow), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);

        // 1.0 + 2.0, with a stray in_last (no valid) in between
        push(32'h3F80_0000, 1'b0);
        bus.in_last = 1'b1;
        @(negedge clk);
        bus.in_last = 1'b0;
        chk("t1_no_early_valid", 32'(bus.out_valid), 32'd0);
        push(32'h4000_0000, 1'b1);
        expect_result("t1", 32'h4040_0000, 16'd2, 1'b0, 1'b0);

        push(32'h4049_0FDB, 1'b1);
        expect_result("t2", 32'h4049_0FDB, 16'd1, 1'b0, 1'b0);

        push(32'h0000_0000, 1'b0);
        push(32'h3F80_0000, 1'b1);
        expect_result("t3a", 32'h3F80_0000, 16'd2, 1'b0, 1'b0);

        push(32'h4000_0000, 1'b0);
        push(32'hC000_0000, 1'b1);
        expect_result("t3b", 32'h0000_0000, 16'd2, 1'b0, 1'b0);

        push(32'h7F00_0000, 1'b0);
        push(32'h7F00_0000, 1'b1);
        expect_result("t4", 32'h7F80_0000, 16'd2, 1'b1, 1'b0);

        // infinity keeps accumulating, flag stays sticky
        push(32'h7F00_0000, 1'b0);
        push(32'h7F00_0000, 1'b0);
        push(32'h3F80_0000, 1'b1);
        expect_result("t4b", 32'h7F80_0000, 16'd3, 1'b1, 1'b0);

        push(32'h3F80_0000, 1'b0);
        push(32'h3F80_0000, 1'b0);
        push(32'hBF80_0000, 1'b1);
        expect_result("t7_sub", 32'h3F80_0000, 16'd3, 1'b0, 1'b0);

        // 1 + 2^-24 is an exact tie: rounds to even
        push(32'h3F80_0000, 1'b0);
        push(32'h3380_0000, 1'b1);
        expect_result("t7_tie", 32'h3F80_0000, 16'd2, 1'b0, 1'b0);

        push(32'h3F80_0000, 1'b0);
        push(32'h3400_0000, 1'b1);
        expect_result("t7_ulp", 32'h3F80_0001, 16'd2, 1'b0, 1'b0);

        // min normal minus a subnormal lands in the subnormal range
        push(32'h0080_0000, 1'b0);
        push(32'h8040_0000, 1'b1);
        expect_result("t7_unf", 32'h0040_0000, 16'd2, 1'b0, 1'b1);

        // backpressure with a pending operand that must not be taken
        push(32'h3F80_0000, 1'b0);
        push(32'h3F80_0000, 1'b1);
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h1234_5678;
        bus.in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("t5_hold_valid", 32'(bus.out_valid), 32'd1);
            chk("t5_hold_sum", bus.out_sum, 32'h4000_0000);
            chk("t5_hold_count", 32'(bus.out_count), 32'd2);
            chk("t5_hold_in_ready", 32'(bus.in_ready), 32'd0);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        expect_result("t5", 32'h4000_0000, 16'd2, 1'b0, 1'b0);

        // reset in the middle of a stream
        push(32'h3F80_0000, 1'b0);
        push(32'h4000_0000, 1'b0);
        chk("t6_pre_valid", 32'(bus.out_valid), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("t6_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("t6_rst_sum", bus.out_sum, 32'd0);
        chk("t6_rst_count", 32'(bus.out_count), 32'd0);
        chk("t6_rst_ovf", 32'(bus.out_overflow), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        push(32'h3F80_0000, 1'b1);
        expect_result("t6", 32'h3F80_0000, 16'd1, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
